// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and types for the digit-serial BCD subtractor
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [4:0] BCD_BASE = 5'd10;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/bcd_digit_sub.sv
// rtl/bcd_digit_sub.sv - single BCD digit subtract with borrow, combinational
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  digit_t a_d,
    input  digit_t b_d,
    input  logic   bi,
    output digit_t d,
    output logic   bo,
    output logic   bad
);

    logic signed [4:0] t;
    logic signed [4:0] t_fix;

    // a - b - borrow in 5-bit signed; a negative result wraps by adding ten
    always_comb begin
        t     = $signed({1'b0, a_d}) - $signed({1'b0, b_d}) - $signed({4'b0000, bi});
        bo    = 1'b0;
        t_fix = t;
        if (t < 0) begin
            bo    = 1'b1;
            t_fix = t + $signed(BCD_BASE);
        end
        d   = t_fix[3:0];
        bad = (a_d > BCD_MAX) || (b_d > BCD_MAX);
    end

endmodule

// File: rtl/bcd_sub_serial.sv
// rtl/bcd_sub_serial.sv - digit-serial BCD subtractor A-B-bin, optional BCD_SUB_CHECK_EN digit check
module bcd_sub_serial
    import bcd_pkg::*;
#(
    parameter int NDIG = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DIGIT_W*NDIG-1:0] a,
    input  logic [DIGIT_W*NDIG-1:0] b,
    input  logic                    bin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DIGIT_W*NDIG-1:0] diff,
    output logic                    bout,
    output logic                    err
);

    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    state_t                    state_q, state_d;
    logic [DIGIT_W*NDIG-1:0]   opa_q, opa_d;
    logic [DIGIT_W*NDIG-1:0]   opb_q, opb_d;
    logic [DIGIT_W*NDIG-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      borrow_q, borrow_d;
    logic                      bout_q, bout_d;

    digit_t cur_a;
    digit_t cur_b;
    digit_t dig_d;
    logic   dig_bo;
    logic   dig_bad;

    // select the operand digits addressed by the counter
    always_comb begin
        cur_a = '0;
        cur_b = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                cur_a = opa_q[DIGIT_W*i +: DIGIT_W];
                cur_b = opb_q[DIGIT_W*i +: DIGIT_W];
            end
        end
    end

    bcd_digit_sub u_digit (
        .a_d (cur_a),
        .b_d (cur_b),
        .bi  (borrow_q),
        .d   (dig_d),
        .bo  (dig_bo),
        .bad (dig_bad)
    );

`ifdef BCD_SUB_CHECK_EN
    logic err_q, err_d;
`else
    logic unused_bad;
    assign unused_bad = dig_bad;
`endif

    // next-state: accept in IDLE, one digit per cycle in CALC, hold in DONE
    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
`ifdef BCD_SUB_CHECK_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opa_d    = a;
                    opb_d    = b;
                    borrow_d = bin;
                    diff_d   = '0;
                    bout_d   = 1'b0;
                    cnt_d    = '0;
`ifdef BCD_SUB_CHECK_EN
                    err_d    = 1'b0;
`endif
                    state_d  = CALC;
                end
            end
            CALC: begin
                for (int i = 0; i < NDIG; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        diff_d[DIGIT_W*i +: DIGIT_W] = dig_d;
                    end
                end
                borrow_d = dig_bo;
`ifdef BCD_SUB_CHECK_EN
                err_d    = err_q | dig_bad;
`endif
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    bout_d  = dig_bo;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
        end
    end

`ifdef BCD_SUB_CHECK_EN
    // sticky non-BCD flag, cleared on the next acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule

// File: tb/tb_bcd_sub_serial.sv
// tb/tb_bcd_sub_serial.sv - directed self-checking bench for bcd_sub_serial
module tb_bcd_sub_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       bout;
    logic       err;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    bcd_sub_serial #(.NDIG(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .err       (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present one operation, then scramble inputs and wait for out_valid
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                          output int lat);
        a        = av;
        b        = bv;
        bin      = bi;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = 8'h55;
        b        = 8'h66;
        bin      = 1'b1;
        lat      = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 || bout !== 1'b0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b diff=%h bout=%b err=%b, need 1 0 00 0 0",
                     in_ready, out_valid, diff, bout, err);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_out_ready: in_ready=%b out_valid=%b, need 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        int lat;
        run_op(8'h72, 8'h45, 1'b0, lat);
        tests_run++;
        if (lat !== 2) begin
            tests_failed++;
            $display("FAIL latency: %0d edges after accept, need 2", lat);
        end
        tests_run++;
        if (diff !== 8'h27 || bout !== 1'b0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL sub_72_45: diff=%h bout=%b in_ready=%b, need 27 0 0", diff, bout, in_ready);
        end
        release_result();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL release: out_valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_negative();
        int lat;
        run_op(8'h45, 8'h72, 1'b0, lat);
        tests_run++;
        if (lat >= 50 || diff !== 8'h73 || bout !== 1'b1) begin
            tests_failed++;
            $display("FAIL sub_45_72: lat=%0d diff=%h bout=%b, need 73 1", lat, diff, bout);
        end
        release_result();
        run_op(8'h99, 8'h99, 1'b0, lat);
        tests_run++;
        if (lat >= 50 || diff !== 8'h00 || bout !== 1'b0) begin
            tests_failed++;
            $display("FAIL sub_99_99: lat=%0d diff=%h bout=%b, need 00 0", lat, diff, bout);
        end
        release_result();
    endtask

    task automatic test_borrow_ripple();
        int lat;
        run_op(8'h00, 8'h00, 1'b1, lat);
        tests_run++;
        if (lat >= 50 || diff !== 8'h99 || bout !== 1'b1) begin
            tests_failed++;
            $display("FAIL ripple_00_00_b1: lat=%0d diff=%h bout=%b, need 99 1", lat, diff, bout);
        end
        release_result();
    endtask

    task automatic test_back_pressure();
        int lat;
        run_op(8'h30, 8'h15, 1'b0, lat);
        in_valid = 1'b1;
        a        = 8'h11;
        b        = 8'h22;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 8'h15 || bout !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_%0d: out_valid=%b in_ready=%b diff=%h bout=%b, need 1 0 15 0",
                         i, out_valid, in_ready, diff, bout);
            end
        end
        in_valid = 1'b0;
        release_result();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        a        = 8'h72;
        b        = 8'h45;
        bin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 8'h00 || bout !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_calc: out_valid=%b in_ready=%b diff=%h bout=%b, need 0 1 00 0",
                     out_valid, in_ready, diff, bout);
        end
        tick();
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_no_valid: out_valid=%b, need 0", out_valid);
        end
        run_op(8'h14, 8'h06, 1'b0, lat);
        tests_run++;
        if (lat >= 50 || diff !== 8'h08 || bout !== 1'b0) begin
            tests_failed++;
            $display("FAIL sub_14_06: lat=%0d diff=%h bout=%b, need 08 0", lat, diff, bout);
        end
        release_result();
    endtask

    task automatic test_check();
        int lat;
        run_op(8'h3A, 8'h01, 1'b0, lat);
`ifdef BCD_SUB_CHECK_EN
        tests_run++;
        if (lat >= 50 || err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_set: lat=%0d err=%b, need 1", lat, err);
        end
`else
        tests_run++;
        if (lat >= 50 || err !== 1'b0 || diff !== 8'h39 || bout !== 1'b0) begin
            tests_failed++;
            $display("FAIL nonbcd_nochk: lat=%0d err=%b diff=%h bout=%b, need 0 39 0", lat, err, diff, bout);
        end
`endif
        release_result();
        run_op(8'h10, 8'h01, 1'b0, lat);
        tests_run++;
        if (lat >= 50 || err !== 1'b0 || diff !== 8'h09 || bout !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_clear: lat=%0d err=%b diff=%h bout=%b, need 0 09 0", lat, err, diff, bout);
        end
        release_result();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        bin       = 1'b0;
        test_reset();
        test_basic();
        test_negative();
        test_borrow_ripple();
        test_back_pressure();
        test_reset_mid_calc();
        test_check();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
